// File: rtl/data_ram.sv
// Byte-addressable 64-bit data RAM for the MMIO RAM window.
// Combinational aligned-doubleword reads; byte-masked stores commit on the falling clock edge.
module data_ram #(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
  parameter int          DEPTH     = 1024,
  parameter int          DATA_W    = 64,
  parameter int          ADDR_W    = 64,
  parameter int          WDT_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] mem_raddr,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_wen,
  input  logic              mem_ren,
  input  logic [WDT_W-1:0]  wdt_op,
  output logic [DATA_W-1:0] mem_rdata
);

  localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] WIN_BYTES = ADDR_W'(DEPTH) * ADDR_W'(8);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Offsets below BASE wrap to huge unsigned values, so one compare covers both bounds.
  logic [ADDR_W-1:0] roff, woff;
  logic              rd_hit, wr_hit;
  logic [IDX_W-1:0]  ridx, widx;
  logic [2:0]        wbyte;

  assign roff   = mem_raddr - BASE;
  assign woff   = mem_waddr - BASE;
  assign rd_hit = mem_ren && (roff < WIN_BYTES);
  assign wr_hit = mem_wen && (woff < WIN_BYTES);
  assign ridx   = IDX_W'(roff >> 3);
  assign widx   = IDX_W'(woff >> 3);
  assign wbyte  = mem_waddr[2:0];

  assign mem_rdata = rd_hit ? mem_q[ridx] : '0;

  logic [7:0]        size_mask;
  logic [7:0]        wmask;
  logic [DATA_W-1:0] wdata_sh;
  logic              we;

  always_comb begin
    size_mask = 8'h00;
    unique case (wdt_op)
      4'b0001: size_mask = 8'h01;
      4'b0010: size_mask = 8'h03;
      4'b0100: size_mask = 8'h0F;
      4'b1000: size_mask = 8'hFF;
      default: size_mask = 8'h00;
    endcase
  end

  // 8-bit lane mask drops lanes past the doubleword boundary instead of wrapping.
  assign wmask    = size_mask << wbyte;
  assign wdata_sh = mem_wdata << {wbyte, 3'b000};
  assign we       = wr_hit && (size_mask != 8'h00);

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      for (int b = 0; b < 8; b++)
        if (wmask[b]) mem_q[widx][8*b +: 8] <= wdata_sh[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_data_ram.sv
// Directed bench for data_ram: masked stores, window bounds, same-cycle access and reset.
module tb_data_ram;

  localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
  localparam int          DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] mem_raddr = '0, mem_waddr = '0, mem_wdata = '0;
  logic        mem_wen = 1'b0, mem_ren = 1'b0;
  logic [3:0]  wdt_op = '0;
  logic [63:0] mem_rdata;

  int n_chk = 0;
  int n_err = 0;

  data_ram #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_ren(mem_ren),
    .wdt_op(wdt_op), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input logic [63:0] addr, input logic [63:0] exp);
    mem_raddr = addr;
    mem_ren   = 1'b1;
    #1;
    chk(tag, mem_rdata, exp);
  endtask

  task automatic wr(input logic [63:0] addr, input logic [63:0] data, input logic [3:0] op);
    @(posedge clk); #1;
    mem_waddr = addr; mem_wdata = data; wdt_op = op; mem_wen = 1'b1;
    @(negedge clk); #1;
    mem_wen = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    do_reset();
    rd_chk("rst_rd", BASE, 64'h0);
    mem_ren = 1'b0; #1;
    chk("rst_ren0", mem_rdata, 64'h0);

    wr(BASE + 64'h8, 64'h1122334455667788, 4'b1000);
    rd_chk("dw_rd", BASE + 64'h8, 64'h1122334455667788);
    rd_chk("dw_rd_unaligned", BASE + 64'hC, 64'h1122334455667788);
    mem_ren = 1'b0; #1;
    chk("ren0_populated", mem_rdata, 64'h0);

    wr(BASE + 64'hA, 64'hFFFF_FFFF_FFFF_FFAB, 4'b0001);
    rd_chk("byte_st", BASE + 64'h8, 64'h1122334455AB7788);
    wr(BASE + 64'hC, 64'hFFFF_FFFF_FFFF_CDEF, 4'b0010);
    rd_chk("half_st", BASE + 64'h8, 64'h1122CDEF55AB7788);

    do_reset();
    rd_chk("rst_clears", BASE + 64'h8, 64'h0);
    wr(BASE + 64'h6, 64'h0000_0000_DEAD_BEEF, 4'b0100);
    rd_chk("spill_lo", BASE, 64'hBEEF_0000_0000_0000);
    rd_chk("spill_no_wrap", BASE + 64'h8, 64'h0);

    wr(64'h0000_0000_7FFF_FFF8, 64'hA5A5_A5A5_A5A5_A5A5, 4'b1000);
    rd_chk("below_rd", 64'h0000_0000_7FFF_FFF8, 64'h0);
    rd_chk("below_nochg_last", BASE + 64'(DEPTH*8 - 8), 64'h0);
    rd_chk("below_nochg_first", BASE, 64'hBEEF_0000_0000_0000);
    wr(BASE + 64'(DEPTH*8), 64'h5A5A_5A5A_5A5A_5A5A, 4'b1000);
    rd_chk("above_rd", BASE + 64'(DEPTH*8), 64'h0);
    rd_chk("above_nochg_last", BASE + 64'(DEPTH*8 - 8), 64'h0);
    wr(BASE + 64'(DEPTH*8 - 8), 64'h0F0E_0D0C_0B0A_0908, 4'b1000);
    rd_chk("last_word", BASE + 64'(DEPTH*8 - 4), 64'h0F0E_0D0C_0B0A_0908);

    wr(BASE, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0101);
    rd_chk("multihot", BASE, 64'hBEEF_0000_0000_0000);
    wr(BASE, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0000);
    rd_chk("zero_op", BASE, 64'hBEEF_0000_0000_0000);

    wr(BASE + 64'h10, 64'h0123_4567_89AB_CDEF, 4'b1000);
    @(posedge clk); #1;
    mem_raddr = BASE + 64'h10; mem_ren = 1'b1;
    mem_waddr = BASE + 64'h10; mem_wdata = 64'hFEDC_BA98_7654_3210; wdt_op = 4'b1000; mem_wen = 1'b1;
    #1;
    chk("same_cyc_old", mem_rdata, 64'h0123_4567_89AB_CDEF);
    @(negedge clk); #1;
    chk("same_cyc_new", mem_rdata, 64'hFEDC_BA98_7654_3210);
    mem_wen = 1'b0;

    @(posedge clk); #1;
    mem_waddr = BASE + 64'h18; mem_wdata = 64'h7777_7777_7777_7777; wdt_op = 4'b1000; mem_wen = 1'b1;
    mem_raddr = BASE + 64'h10; mem_ren = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_async_clear", mem_rdata, 64'h0);
    @(negedge clk); #1;
    mem_raddr = BASE + 64'h18; #1;
    chk("rst_blocks_wr", mem_rdata, 64'h0);
    rst_n = 1'b1;
    mem_wen = 1'b0;
    #1;
    rd_chk("rst_wr_lost", BASE + 64'h18, 64'h0);
    rd_chk("rst_last_clear", BASE + 64'(DEPTH*8 - 8), 64'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
